ff_sweep_sequencer: RTL and testbench
=====================================

Name: ff_sweep_sequencer

Overview:
- Controller that sequences a combinational/flip-flop excitation circuit under test (CUT) through every input combination.
- Drives an N_IN-bit stimulus vector {s, r, q} in ascending binary order, waits a settle interval, samples the CUT's 1-bit response and compares it against a programmable expected truth table.
- Reports mismatch count, first failing vector and pass/fail.
- Sits between the lab top-level (start button/switches) and the flip-flop conversion circuits; replaces hand-written stimulus sequences.

Parameters:
- N_IN, 3, stimulus width; sweeps 2**N_IN vectors (MSB = s, then r, LSB = q for N_IN=3).
- SETTLE_CYC, 1, cycles held before sampling; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a sweep when idle.
- abort  input  1  terminates the sweep; returns to IDLE.
- exp_tbl  input  2**N_IN  expected response; bit i = expected output for stimulus i.
- cut_resp  input  1  response from the CUT.
- stim  output  N_IN  stimulus vector to the CUT.
- busy  output  1  high while the sweep is in progress.
- done  output  1  one-cycle pulse at sweep completion.
- pass  output  1  valid from done onward; 1 when mismatch count is 0.
- err_cnt  output  N_IN+1  number of mismatching vectors.
- first_fail  output  N_IN  index of the first mismatch; 0 when none.
- fail_seen  output  1  at least one mismatch in the current/last sweep.

Behaviour:
- Reset (async assert, synchronous-edge release): state IDLE; stim=0, busy=0, done=0, pass=0, err_cnt=0, first_fail=0, fail_seen=0.
- States: IDLE, HOLD, SAMPLE, DONE.
- IDLE:
  - On start=1 (abort=0): latch exp_tbl into an internal copy; clear err_cnt, first_fail, fail_seen and pass; set stim=0 and busy=1; go to HOLD with the settle counter at SETTLE_CYC-1.
  - exp_tbl changes after the start edge do not affect the run.
- HOLD: decrement the settle counter each cycle; at 0, go to SAMPLE. stim is stable throughout.
- SAMPLE (one cycle): compare cut_resp against tbl[stim].
  - On mismatch: err_cnt+1; if fail_seen=0, first_fail=stim and fail_seen=1.
  - If stim == 2**N_IN-1, go to DONE; otherwise stim+1, reload the settle counter, go to HOLD.
- Timing: each vector occupies SETTLE_CYC+1 cycles. The start-accept edge to the DONE entry edge is 2**N_IN*(SETTLE_CYC+1) cycles (16 for the defaults).
- DONE (one cycle): done=1, busy=0, pass=(err_cnt==0); return to IDLE.
  - stim returns to 0 on DONE entry.
  - Results (pass, err_cnt, first_fail, fail_seen) hold until the next accepted start.
- Wrap-around: stim never wraps during a sweep; the last vector ends the run. err_cnt is sized to hold 2**N_IN without overflow.
- start while busy: ignored.
- start and abort in the same cycle in IDLE: abort wins and nothing starts.
- abort while busy (any non-IDLE state): next edge goes to IDLE with stim=0 and busy=0. No done pulse; pass=0. err_cnt, first_fail and fail_seen keep partial values.
- abort in SAMPLE: the compare in that cycle is discarded.
- rst mid-sweep: immediate return to reset values; no done pulse.
- cut_resp is assumed synchronous to clk (sampled directly; no synchroniser).

Decomposition:
- Package ff_sweep_pkg:
  - state enum type (IDLE, HOLD, SAMPLE, DONE);
  - localparam SETTLE_W=4;
  - function expected_bit(tbl, idx).
- One natural sub-module: ff_sweep_settle_cnt, a loadable down-counter with a zero flag, instantiated once.
- The FSM, compare and result registers stay in the top.

Test Plan:
- Defaults; model CUT as the SR-to-T converter (t=1 only for {s,r,q}=011 and 100); exp_tbl=8'b0001_1000; start -> stim steps 0..7, 2 cycles each; done at cycle 16 after start; pass=1, err_cnt=0, fail_seen=0.
- Same CUT, exp_tbl=8'b0001_1001 -> err_cnt=1, first_fail=0, fail_seen=1, pass=0.
- CUT tied to 1, exp_tbl=8'h00 -> err_cnt=8, first_fail=0. Repeat with exp_tbl=8'hF0 -> err_cnt=4, first_fail=0.
- Assert abort while stim=3 in HOLD -> next cycle busy=0, stim=0; no done pulse; new start re-runs cleanly with err_cnt cleared.
- start pulsed again at stim=5 -> ignored, sweep finishes at the nominal cycle. Toggle exp_tbl mid-run -> results unaffected.
- Assert rst asynchronously at stim=6 -> all outputs 0 immediately (before the next edge). SETTLE_CYC=3 run -> each stim held 4 cycles, done at cycle 32.

Source files
------------

// File: rtl/ff_sweep_pkg.sv
// Shared types, widths and helpers for the flip-flop excitation sweep sequencer.
package ff_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int unsigned SETTLE_W  = 4;
  localparam int unsigned IDX_W     = 8;
  localparam int unsigned MAX_TBL_W = 2 ** IDX_W;

  // Expected CUT response for stimulus idx; callers zero-extend their table.
  function automatic logic expected_bit(input logic [MAX_TBL_W-1:0] tbl,
                                        input logic [IDX_W-1:0]     idx);
    return tbl[idx];
  endfunction

endpackage

// File: rtl/ff_sweep_sequencer_if.sv
// Control, stimulus and result signals between the lab top, the sequencer and the CUT.
interface ff_sweep_sequencer_if #(
  parameter int unsigned N_IN = 3
);
  localparam int unsigned NV = 2 ** N_IN;

  logic              start;
  logic              abort;
  logic [NV-1:0]     exp_tbl;
  logic              cut_resp;
  logic [N_IN-1:0]   stim;
  logic              busy;
  logic              done;
  logic              pass;
  logic [N_IN:0]     err_cnt;
  logic [N_IN-1:0]   first_fail;
  logic              fail_seen;

  // Sequencer side.
  modport master (
    input  start, abort, exp_tbl, cut_resp,
    output stim, busy, done, pass, err_cnt, first_fail, fail_seen
  );

  // Lab top / CUT side.
  modport slave (
    output start, abort, exp_tbl, cut_resp,
    input  stim, busy, done, pass, err_cnt, first_fail, fail_seen
  );

endinterface

// File: rtl/ff_sweep_settle_cnt.sv
// Loadable settle down-counter; saturates at zero and flags it combinationally.
module ff_sweep_settle_cnt
  import ff_sweep_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                dec,
  input  logic [SETTLE_W-1:0] load_val,
  output logic                zero_c
);

  logic [SETTLE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - SETTLE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/ff_sweep_sequencer.sv
// Sweeps every stimulus vector through the CUT, compares its response with a
// latched truth table and reports mismatch count, first failing vector and pass.
module ff_sweep_sequencer
  import ff_sweep_pkg::*;
#(
  parameter int unsigned N_IN       = 3,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  ff_sweep_sequencer_if.master bus
);

  localparam int unsigned NV    = 2 ** N_IN;
  localparam int unsigned CNT_W = N_IN + 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC - 1);
  localparam logic [N_IN-1:0]     LAST_STIM   = N_IN'(NV - 1);

  state_e            state_q, state_d;
  logic [N_IN-1:0]   stim_q, stim_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [N_IN-1:0]   first_fail_q, first_fail_d;
  logic              fail_seen_q, fail_seen_d;
  logic [NV-1:0]     tbl_q, tbl_d;

  logic              cnt_load_c;
  logic              cnt_dec_c;
  logic              cnt_zero_c;
  logic              mismatch_c;

  ff_sweep_settle_cnt u_settle_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_c),
    .dec      (cnt_dec_c),
    .load_val (SETTLE_LOAD),
    .zero_c   (cnt_zero_c)
  );

  always_comb begin
    state_d      = state_q;
    stim_d       = stim_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    err_cnt_d    = err_cnt_q;
    first_fail_d = first_fail_q;
    fail_seen_d  = fail_seen_q;
    tbl_d        = tbl_q;
    cnt_load_c   = 1'b0;
    cnt_dec_c    = 1'b0;
    mismatch_c   = (bus.cut_resp != expected_bit(MAX_TBL_W'(tbl_q), IDX_W'(stim_q)));

    // Abort drops any in-flight compare but leaves partial results visible.
    if ((state_q != IDLE) && bus.abort) begin
      state_d = IDLE;
      stim_d  = '0;
      busy_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            tbl_d        = bus.exp_tbl;
            err_cnt_d    = '0;
            first_fail_d = '0;
            fail_seen_d  = 1'b0;
            pass_d       = 1'b0;
            stim_d       = '0;
            busy_d       = 1'b1;
            cnt_load_c   = 1'b1;
            state_d      = HOLD;
          end
        end
        HOLD: begin
          if (cnt_zero_c) begin
            state_d = SAMPLE;
          end else begin
            cnt_dec_c = 1'b1;
          end
        end
        SAMPLE: begin
          if (mismatch_c) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
            if (!fail_seen_q) begin
              first_fail_d = stim_q;
              fail_seen_d  = 1'b1;
            end
          end
          // Last vector ends the run; stim never wraps mid-sweep.
          if (stim_q == LAST_STIM) begin
            state_d = DONE;
            stim_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_cnt_d == '0);
          end else begin
            stim_d     = stim_q + N_IN'(1);
            cnt_load_c = 1'b1;
            state_d    = HOLD;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      stim_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_cnt_q    <= '0;
      first_fail_q <= '0;
      fail_seen_q  <= 1'b0;
      tbl_q        <= '0;
    end else begin
      state_q      <= state_d;
      stim_q       <= stim_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_cnt_q    <= err_cnt_d;
      first_fail_q <= first_fail_d;
      fail_seen_q  <= fail_seen_d;
      tbl_q        <= tbl_d;
    end
  end

  assign bus.stim       = stim_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.first_fail = first_fail_q;
  assign bus.fail_seen  = fail_seen_q;

endmodule

// File: tb/tb_ff_sweep_sequencer.sv
// Self-checking bench: table of sweeps scored through a queue, plus abort/reset/settle corner cases.
module tb_ff_sweep_sequencer;

  typedef struct {
    string      name;
    bit         cut_one;
    logic [7:0] tbl;
    logic [3:0] err;
    logic [2:0] ff;
    logic       fs;
    logic       pass;
  } vec_t;

  typedef struct {
    string      name;
    int         done_cyc;
    logic [3:0] err;
    logic [2:0] ff;
    logic       fs;
    logic       pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   cut_one0 = 1'b0;
  int   c0;
  bit   seen1;
  exp_t sb_q[$];
  vec_t vecs[6];

  ff_sweep_sequencer_if #(.N_IN(3)) bus0 ();
  ff_sweep_sequencer_if #(.N_IN(3)) bus1 ();

  ff_sweep_sequencer #(.N_IN(3), .SETTLE_CYC(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  ff_sweep_sequencer #(.N_IN(3), .SETTLE_CYC(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SR-to-T converter: toggle needed only for {s,r,q} = 011 and 100.
  always_comb bus0.cut_resp = cut_one0 | (bus0.stim == 3'd3) | (bus0.stim == 3'd4);
  always_comb bus1.cut_resp = (bus1.stim == 3'd3) | (bus1.stim == 3'd4);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic watch_no_done(input string nm, input int n);
    bit saw;
    saw = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      saw = saw | bus0.done;
    end
    chk(nm, 32'(saw), 32'd0);
  endtask

  task automatic take_done0();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done: done pulse with no sweep pending (cycle %0d)", cyc);
      return;
    end
    e = sb_q.pop_front();
    chk({e.name, "_done_cyc"}, cyc, e.done_cyc);
    chk({e.name, "_err_cnt"}, 32'(bus0.err_cnt), 32'(e.err));
    chk({e.name, "_first_fail"}, 32'(bus0.first_fail), 32'(e.ff));
    chk({e.name, "_fail_seen"}, 32'(bus0.fail_seen), 32'(e.fs));
    chk({e.name, "_pass"}, 32'(bus0.pass), 32'(e.pass));
    chk({e.name, "_busy_done"}, 32'(bus0.busy), 32'd0);
    chk({e.name, "_stim_done"}, 32'(bus0.stim), 32'd0);
    @(negedge clk);
    chk({e.name, "_done_width"}, 32'(bus0.done), 32'd0);
    chk({e.name, "_pass_hold"}, 32'(bus0.pass), 32'(e.pass));
    chk({e.name, "_err_hold"}, 32'(bus0.err_cnt), 32'(e.err));
  endtask

  // hook: 0 plain, 1 restart at stim 5, 2 exp_tbl churn, 3 abort at stim 3, 4 rst at stim 6
  task automatic sweep0(input vec_t v, input int hook);
    exp_t e;
    bit   seen;
    seen          = 1'b0;
    cut_one0      = v.cut_one;
    bus0.exp_tbl  = v.tbl;
    bus0.start    = 1'b1;
    @(negedge clk);
    bus0.start    = 1'b0;
    e.name = v.name;
    e.done_cyc = cyc + 16;
    e.err = v.err;
    e.ff = v.ff;
    e.fs = v.fs;
    e.pass = v.pass;
    if (hook < 3) sb_q.push_back(e);
    for (int k = 0; k < 40; k++) begin
      if (bus0.done) begin
        take_done0();
        seen = 1'b1;
        break;
      end
      if (k < 16) begin
        chk({v.name, "_stim"}, 32'(bus0.stim), k / 2);
        chk({v.name, "_busy"}, 32'(bus0.busy), 32'd1);
      end
      if (hook == 1 && k == 10) bus0.start = 1'b1;
      if (hook == 1 && k == 11) bus0.start = 1'b0;
      if (hook == 2 && k == 5) bus0.exp_tbl = ~v.tbl;
      if (hook == 2 && k == 9) bus0.exp_tbl = 8'h5A;
      if (hook == 3 && k == 6) begin
        bus0.abort = 1'b1;
        @(negedge clk);
        bus0.abort = 1'b0;
        chk("abort_busy", 32'(bus0.busy), 32'd0);
        chk("abort_stim", 32'(bus0.stim), 32'd0);
        chk("abort_pass", 32'(bus0.pass), 32'd0);
        chk("abort_err_partial", 32'(bus0.err_cnt), 32'd3);
        chk("abort_ff_partial", 32'(bus0.first_fail), 32'd0);
        chk("abort_fs_partial", 32'(bus0.fail_seen), 32'd1);
        watch_no_done("abort_no_done", 20);
        return;
      end
      if (hook == 4 && k == 12) begin
        chk("rst_pre_err", 32'(bus0.err_cnt), 32'd6);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_stim", 32'(bus0.stim), 32'd0);
        chk("rst_async_busy", 32'(bus0.busy), 32'd0);
        chk("rst_async_err", 32'(bus0.err_cnt), 32'd0);
        chk("rst_async_fs", 32'(bus0.fail_seen), 32'd0);
        chk("rst_async_done_pass", 32'({bus0.done, bus0.pass, bus0.first_fail}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        watch_no_done("rst_no_done", 20);
        return;
      end
      @(negedge clk);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no done within 40 cycles, expected at cycle %0d", v.name, e.done_cyc);
      if (sb_q.size() > 0) sb_q.delete(0);
    end
  endtask

  initial begin
    vecs[0] = '{"sr2t_ok",   1'b0, 8'h18, 4'd0, 3'd0, 1'b0, 1'b1};
    vecs[1] = '{"sr2t_bit0", 1'b0, 8'h19, 4'd1, 3'd0, 1'b1, 1'b0};
    vecs[2] = '{"one_00",    1'b1, 8'h00, 4'd8, 3'd0, 1'b1, 1'b0};
    vecs[3] = '{"one_f0",    1'b1, 8'hF0, 4'd4, 3'd0, 1'b1, 1'b0};
    vecs[4] = '{"one_0f",    1'b1, 8'h0F, 4'd4, 3'd4, 1'b1, 1'b0};
    vecs[5] = '{"sr2t_80",   1'b0, 8'h80, 4'd3, 3'd3, 1'b1, 1'b0};

    bus0.start = 1'b0; bus0.abort = 1'b0; bus0.exp_tbl = '0;
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.exp_tbl = '0;
    repeat (3) @(negedge clk);

    chk("reset_stim", 32'(bus0.stim), 32'd0);
    chk("reset_busy", 32'(bus0.busy), 32'd0);
    chk("reset_done", 32'(bus0.done), 32'd0);
    chk("reset_pass", 32'(bus0.pass), 32'd0);
    chk("reset_err_cnt", 32'(bus0.err_cnt), 32'd0);
    chk("reset_first_fail", 32'(bus0.first_fail), 32'd0);
    chk("reset_fail_seen", 32'(bus0.fail_seen), 32'd0);
    chk("reset_dut1", 32'({bus1.stim, bus1.busy, bus1.done, bus1.pass, bus1.err_cnt,
                           bus1.first_fail, bus1.fail_seen}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      sweep0(vecs[i], 0);
      @(negedge clk);
    end

    sweep0(vecs[1], 1);
    @(negedge clk);
    sweep0(vecs[5], 2);
    @(negedge clk);

    // start and abort together in IDLE: nothing starts, results hold.
    bus0.start = 1'b1;
    bus0.abort = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    bus0.abort = 1'b0;
    chk("start_abort_busy", 32'(bus0.busy), 32'd0);
    chk("start_abort_err_hold", 32'(bus0.err_cnt), 32'd3);
    watch_no_done("start_abort_no_done", 20);

    sweep0(vecs[2], 3);
    sweep0(vecs[0], 0);
    @(negedge clk);

    sweep0(vecs[2], 4);
    @(negedge clk);

    // SETTLE_CYC=3 instance: each vector held 4 cycles, done 32 cycles after start.
    bus1.exp_tbl = 8'h18;
    bus1.start   = 1'b1;
    @(negedge clk);
    bus1.start   = 1'b0;
    c0    = cyc;
    seen1 = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (bus1.done) begin
        chk("s3_done_cyc", cyc, c0 + 32);
        chk("s3_pass", 32'(bus1.pass), 32'd1);
        chk("s3_err_cnt", 32'(bus1.err_cnt), 32'd0);
        seen1 = 1'b1;
        break;
      end
      if (k < 32) chk("s3_stim", 32'(bus1.stim), k / 4);
      @(negedge clk);
    end
    if (!seen1) begin
      checks++;
      errors++;
      $display("FAIL s3_timeout: no done within 60 cycles, expected at cycle %0d", c0 + 32);
    end

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
